shift_chain_ctrl: RTL and testbench
===================================

Name: shift_chain_ctrl

Overview:
Flow controller for a chain of STAGES 4-bit shift-register stages that share one clock enable (Ce), such as the three-stage week04fourth delay line.
- Generates the shared Ce and keeps a valid-bit shadow of every stage.
- Gives the upstream source and the downstream consumer valid/ready handshakes.
- Drains the chain on request or after an input-idle timeout.
- The datapath is external; the block drives only Ce and control/status signals.

Parameters:
STAGES, 3, number of chained stages (2..8)
IDLE_TO, 4, cycles in RUN with in_valid low and occupancy>0 before auto-drain (>=1)
CNT_W, 8, width of delivered-word counter

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous reset, active-low
in_valid  input  1  upstream word present on chain Din
in_ready  output  1  chain can accept a word this cycle
out_ready  input  1  consumer can take last-stage Dout
out_valid  output  1  last stage holds a valid word
flush  input  1  request drain of all held words
Ce  output  1  shared clock enable to every chain stage
occupancy  output  clog2(STAGES+1)  number of valid stages
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when a drain completes
word_cnt  output  CNT_W  words delivered (saturating)

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-low on RST. All state updates on the rising CLK edge.
- RST=0 at an edge clears the following: vld=0, state=IDLE, idle_cnt=0, word_cnt=0, done=0. Result is Ce=0, out_valid=0, in_ready=1, occupancy=0, busy=0.
- Reset applies mid-operation from any state. Words held in the datapath become invalid; the chain registers are reset by the same RST.
- Valid shadow: vld[STAGES-1:0]. vld[0] tracks the first stage; vld[STAGES-1] tracks the stage driving Dout.
- out_valid = vld[STAGES-1], registered.
- Combinational outputs:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = (state!=DRAIN) & (!vld[STAGES-1] | out_ready).
  - Ce = in_fire | out_fire | (state==DRAIN & |vld & !vld[STAGES-1]).
- On an edge with Ce=1: vld <= {vld[STAGES-2:0], in_fire}. Ce=0 holds vld.
- out_fire always implies Ce, so the consumed word leaves the last stage and the upstream word advances in the same cycle.
- Latency: a word accepted at an edge (Ce high) appears on Dout after STAGES Ce edges. Throughput is 1 word/cycle with out_ready=1 and in_valid=1.
- Without input or drain, interior words wait for further shifts. An out_fire with no input shifts a bubble into stage 0.
- State machine IDLE / RUN / DRAIN. nxt_vld is the vld value after this edge.
  - IDLE: in_fire -> RUN. flush -> done=1 next cycle, stay IDLE.
  - RUN: flush -> DRAIN. Otherwise idle_cnt==IDLE_TO-1 with in_valid=0 and |nxt_vld -> DRAIN. Otherwise nxt_vld==0 -> IDLE.
  - DRAIN: nxt_vld==0 -> IDLE and done=1 for exactly one cycle. flush is ignored. in_ready=0.
- idle_cnt: cleared on in_valid=1, on leaving RUN, and while occupancy==0. Otherwise increments each RUN cycle.
- flush and in_valid in the same RUN cycle: the word is accepted (in_ready evaluated in RUN), then the state enters DRAIN.
- word_cnt: +1 on each out_fire and saturates at 2^CNT_W-1. Cleared only by reset.
- occupancy = popcount(vld), registered. busy = state!=IDLE.

Test Plan:
- Reset: hold RST=0 for 2 edges mid-stream -> Ce=0, vld=0, out_valid=0, in_ready=1, occupancy=0, word_cnt=0, busy=0, done=0.
- Stream: STAGES=3, in_valid=1 for 6 cycles (Din=1..6), out_ready=1:
  - out_valid rises after the 3rd Ce edge with Dout=1.
  - Dout then reads 2,3 on consecutive cycles while input is still streaming.
  - occupancy stays 3; word_cnt=3 when input stops.
  - busy=1 throughout; state returns to IDLE only after the remaining words are drained.
- Backpressure: occupancy=3, out_ready=0, in_valid=1 -> in_ready=0, Ce=0, vld frozen. Raise out_ready -> Ce=1 the same cycle, word_cnt+1.
- Flush: vld=3'b011, in_valid=0, out_ready=1, pulse flush ->
  - DRAIN; Ce high for 3 cycles; vld goes 110, 100, 000.
  - word_cnt +2; done pulses once; then IDLE with in_ready=1.
- Auto-drain: accept 1 word then in_valid=0 for 4 cycles (IDLE_TO=4) -> DRAIN on the 4th cycle, word delivered, done pulse, IDLE.
- Corners:
  - flush in IDLE -> single done pulse, Ce=0.
  - flush together with in_valid in RUN -> word accepted, then DRAIN.
  - RST=0 mid-DRAIN -> IDLE, occupancy=0 at the next edge, and no done pulse.

Source files
------------

// File: rtl/shift_chain_ctrl.sv
// Flow controller for a chain of shift-register stages that share one clock enable.
// It keeps a valid-bit shadow of the chain and handles the in/out handshakes, draining and done reporting.
module shift_chain_ctrl #(
  parameter int STAGES  = 3,
  parameter int IDLE_TO = 4,
  parameter int CNT_W   = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        out_ready,
  output logic                        out_valid,
  input  logic                        flush,
  output logic                        Ce,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            word_cnt
);

  localparam int OCC_W  = $clog2(STAGES + 1);
  localparam int IDLE_W = $clog2(IDLE_TO + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [STAGES-1:0] vld_reg;
  logic [STAGES-1:0] vld_next;
  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [IDLE_W-1:0] idle_cnt_reg;
  logic [IDLE_W-1:0] idle_cnt_next;
  logic [CNT_W-1:0]  word_cnt_reg;
  logic              done_reg;
  logic              done_next;
  logic [OCC_W-1:0]  occ_reg;
  logic              in_fire;
  logic              out_fire;
  logic [OCC_W-1:0]  pc [0:STAGES];

  assign in_ready = (state_reg != ST_DRAIN) & (~vld_reg[STAGES-1] | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = vld_reg[STAGES-1] & out_ready;
  // While draining, keep shifting until the oldest word sits in the last stage.
  assign Ce       = in_fire | out_fire |
                    ((state_reg == ST_DRAIN) & (|vld_reg) & ~vld_reg[STAGES-1]);
  assign vld_next = Ce ? {vld_reg[STAGES-2:0], in_fire} : vld_reg;

  assign pc[0] = '0;
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_popcount
    assign pc[gi+1] = pc[gi] + OCC_W'(vld_next[gi]);
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_fire) begin
          state_next = ST_RUN;
        end else if (flush) begin
          done_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_next = ST_DRAIN;
        end else if ((idle_cnt_reg == IDLE_W'(IDLE_TO - 1)) && !in_valid && (|vld_next)) begin
          state_next = ST_DRAIN;
        end else if (vld_next == '0) begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (vld_next == '0) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The idle timer only runs while in RUN with words held and no input offered.
  always_comb begin
    idle_cnt_next = '0;
    if ((state_reg == ST_RUN) && (state_next == ST_RUN) && !in_valid && (|vld_reg)) begin
      idle_cnt_next = idle_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      vld_reg      <= '0;
      state_reg    <= ST_IDLE;
      idle_cnt_reg <= '0;
      word_cnt_reg <= '0;
      done_reg     <= 1'b0;
      occ_reg      <= '0;
    end else begin
      vld_reg      <= vld_next;
      state_reg    <= state_next;
      idle_cnt_reg <= idle_cnt_next;
      done_reg     <= done_next;
      occ_reg      <= pc[STAGES];
      if (out_fire && (word_cnt_reg != {CNT_W{1'b1}})) begin
        word_cnt_reg <= word_cnt_reg + 1'b1;
      end
    end
  end

  assign out_valid = vld_reg[STAGES-1];
  assign occupancy = occ_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign word_cnt  = word_cnt_reg;

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Randomised and directed bench for shift_chain_ctrl with an external 4-bit chain datapath.
// A slot-level reference model predicts every output; a FIFO scoreboard checks delivered data.
module tb_shift_chain_ctrl;
  localparam int STAGES  = 3;
  localparam int IDLE_TO = 4;
  localparam int CNT_W   = 8;
  localparam int OCC_W   = $clog2(STAGES + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK;
  logic             RST;
  logic             in_valid;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic             flush;
  logic             Ce;
  logic [OCC_W-1:0] occupancy;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] word_cnt;
  logic [3:0]       din;
  logic [3:0]       chain [STAGES];

  int errors = 0;
  int checks = 0;
  int delivered = 0;
  int exp_q[$];

  shift_chain_ctrl #(.STAGES(STAGES), .IDLE_TO(IDLE_TO), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .flush(flush), .Ce(Ce),
    .occupancy(occupancy), .busy(busy), .done(done), .word_cnt(word_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External datapath: the chain of 4-bit stages sharing Ce and reset.
  always @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= 4'd0;
    end else if (Ce) begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot contents (-1 = empty), mode 0=idle 1=run 2=drain.
  int m_slot[STAGES];
  int m_mode, m_idle, m_cnt, m_done;

  task automatic model_reset();
    for (int i = 0; i < STAGES; i++) m_slot[i] = -1;
    m_mode = 0; m_idle = 0; m_cnt = 0; m_done = 0;
  endtask

  initial begin : monitor
    int n_slot[STAGES];
    int n_mode, n_idle, n_cnt, n_done, occ, n_occ;
    bit rdy, ifire, ofire, ce, last_full;
    @(posedge CLK);
    model_reset();
    forever begin
      @(negedge CLK);
      occ = 0;
      for (int i = 0; i < STAGES; i++) if (m_slot[i] >= 0) occ++;
      last_full = (m_slot[STAGES-1] >= 0);
      rdy   = (m_mode != 2) && (!last_full || out_ready);
      ifire = in_valid && rdy;
      ofire = last_full && out_ready;
      ce    = ifire || ofire || (m_mode == 2 && occ > 0 && !last_full);
      chk("in_ready", int'(in_ready), int'(rdy));
      chk("Ce", int'(Ce), int'(ce));
      chk("out_valid", int'(out_valid), int'(last_full));
      chk("occupancy", int'(occupancy), occ);
      chk("busy", int'(busy), int'(m_mode != 0));
      chk("done", int'(done), m_done);
      chk("word_cnt", int'(word_cnt), m_cnt);
      if (RST && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("dout_unexpected", int'(chain[STAGES-1]), -1);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("dout", int'(chain[STAGES-1]), e);
          delivered++;
          $display("word %0d delivered dout=%0d expected=%0d", delivered, chain[STAGES-1], e);
        end
      end
      if (RST && ifire) exp_q.push_back(int'(din));
      // next model state
      if (!RST) begin
        exp_q.delete();
        @(posedge CLK);
        model_reset();
      end else begin
        if (ce) begin
          for (int i = STAGES - 1; i > 0; i--) n_slot[i] = m_slot[i-1];
          n_slot[0] = ifire ? int'(din) : -1;
        end else begin
          for (int i = 0; i < STAGES; i++) n_slot[i] = m_slot[i];
        end
        n_occ = 0;
        for (int i = 0; i < STAGES; i++) if (n_slot[i] >= 0) n_occ++;
        n_cnt  = (ofire && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
        n_mode = m_mode;
        n_done = 0;
        if (m_mode == 0) begin
          if (ifire) n_mode = 1;
          else if (flush) n_done = 1;
        end else if (m_mode == 1) begin
          if (flush) n_mode = 2;
          else if (m_idle == IDLE_TO - 1 && !in_valid && n_occ > 0) n_mode = 2;
          else if (n_occ == 0) n_mode = 0;
        end else begin
          if (n_occ == 0) begin
            n_mode = 0;
            n_done = 1;
          end
        end
        n_idle = (m_mode == 1 && n_mode == 1 && !in_valid && occ > 0) ? m_idle + 1 : 0;
        @(posedge CLK);
        for (int i = 0; i < STAGES; i++) m_slot[i] = n_slot[i];
        m_mode = n_mode; m_idle = n_idle; m_cnt = n_cnt; m_done = n_done;
      end
    end
  end

  task automatic step(input bit iv, input bit orr, input bit fl, input bit r, input logic [3:0] d);
    in_valid = iv; out_ready = orr; flush = fl; RST = r; din = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
  endtask

  initial begin : stimulus
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; RST = 1'b0; din = 4'd0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // streaming
    for (int i = 1; i <= 6; i++) step(1, 1, 0, 1, 4'(i));
    idle(10);
    // backpressure then release
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 4'(7 + i));
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 4'(12 + i));
    idle(10);
    // flush with two words held
    step(1, 0, 0, 1, 4'd9);
    step(1, 0, 0, 1, 4'd10);
    step(0, 1, 1, 1, 4'd0);
    idle(6);
    // auto-drain after idle timeout
    step(1, 1, 0, 1, 4'd5);
    idle(10);
    // flush in IDLE
    step(0, 1, 1, 1, 4'd0);
    idle(3);
    // flush together with in_valid in RUN
    step(1, 1, 0, 1, 4'd3);
    step(1, 1, 1, 1, 4'd4);
    idle(8);
    // reset in the middle of a drain
    step(1, 0, 0, 1, 4'd1);
    step(1, 0, 1, 1, 4'd2);
    step(0, 0, 0, 1, 4'd0);
    step(0, 0, 0, 0, 4'd0);
    idle(3);
    // long stream to reach word counter saturation
    for (int i = 0; i < 300; i++) step(1, 1, 0, 1, 4'($urandom_range(0, 15)));
    idle(8);
    // randomised traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0,
           ($urandom % 300) != 0, 4'($urandom_range(0, 15)));
    end
    idle(12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
